// File: rtl/axi_arb_pkg.sv
// Shared types and AXI response codes for the two-master read-channel arbiter.
package axi_arb_pkg;

  typedef enum logic [1:0] {IDLE, SEND_AR, WAIT_R} arb_state_e;
  typedef enum logic {MST_IFU, MST_LSU} arb_mst_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick: bit 0 is the IFU, bit 1 the LSU.
module rr_arb2
  import axi_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt,
  output logic       any
);

  // On a tie the master that did not win last time gets the grant.
  assign gnt[0] = req[0] & (~req[1] | (last_grant == MST_LSU));
  assign gnt[1] = req[1] & (~req[0] | (last_grant == MST_IFU));
  assign any    = |req;

endmodule

// File: rtl/axi_rd_arbiter.sv
// AXI-lite read-channel arbiter: IFU and LSU share one slave, one read in flight,
// grant locked from AR acceptance until the R handshake.
module axi_rd_arbiter
  import axi_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ifu_araddr,
  input  logic              ifu_arvalid,
  output logic              ifu_arready,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic [1:0]        ifu_rresp,
  output logic              ifu_rvalid,
  input  logic              ifu_rready,
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic              lsu_arvalid,
  output logic              lsu_arready,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic [1:0]        lsu_rresp,
  output logic              lsu_rvalid,
  input  logic              lsu_rready,
  output logic [ADDR_W-1:0] s_araddr,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rvalid,
  output logic              s_rready
);

  arb_state_e        state_q;
  arb_mst_e          last_grant_q;
  arb_mst_e          owner_q;
  arb_mst_e          owner_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic              s_arvalid_q;
  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              any;
  logic              idle;
  logic              ifu_own;
  logic              lsu_own;

  assign req = {lsu_arvalid, ifu_arvalid};

  rr_arb2 u_rr_arb2 (
    .req        (req),
    .last_grant (last_grant_q),
    .gnt        (gnt),
    .any        (any)
  );

  assign idle        = (state_q == IDLE);
  assign ifu_arready = idle & gnt[0];
  assign lsu_arready = idle & gnt[1];
  assign owner_d     = gnt[1] ? MST_LSU : MST_IFU;
  assign addr_d      = gnt[1] ? lsu_araddr : ifu_araddr;

  assign s_arvalid = s_arvalid_q;
  assign s_araddr  = addr_q;

  // The R channel is steered only to the owner and only while the read is outstanding.
  assign ifu_own  = (state_q == WAIT_R) & (owner_q == MST_IFU);
  assign lsu_own  = (state_q == WAIT_R) & (owner_q == MST_LSU);
  assign s_rready = (ifu_own & ifu_rready) | (lsu_own & lsu_rready);

  assign ifu_rvalid = ifu_own & s_rvalid;
  assign ifu_rdata  = ifu_own ? s_rdata : '0;
  assign ifu_rresp  = ifu_own ? s_rresp : AXI_RESP_OKAY;
  assign lsu_rvalid = lsu_own & s_rvalid;
  assign lsu_rdata  = lsu_own ? s_rdata : '0;
  assign lsu_rresp  = lsu_own ? s_rresp : AXI_RESP_OKAY;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= MST_LSU;
      owner_q      <= MST_IFU;
      addr_q       <= '0;
      s_arvalid_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any) begin
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            s_arvalid_q <= 1'b1;
            state_q     <= SEND_AR;
          end
        end
        SEND_AR: begin
          if (s_arready) begin
            s_arvalid_q <= 1'b0;
            state_q     <= WAIT_R;
          end
        end
        WAIT_R: begin
          // last_grant only moves once the read completes, so a pending loser wins next.
          if (s_rvalid && s_rready) begin
            last_grant_q <= owner_q;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: master/slave drivers, a negedge monitor, directed reads.
module tb_axi_rd_arbiter;
  import axi_arb_pkg::*;

  localparam int   AW  = 32;
  localparam int   DW  = 32;
  localparam logic IFU = 1'b0;
  localparam logic LSU = 1'b1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [AW-1:0] ifu_araddr = '0;
  logic          ifu_arvalid = 1'b0;
  logic          ifu_arready;
  logic [DW-1:0] ifu_rdata;
  logic [1:0]    ifu_rresp;
  logic          ifu_rvalid;
  logic          ifu_rready = 1'b1;
  logic [AW-1:0] lsu_araddr = '0;
  logic          lsu_arvalid = 1'b0;
  logic          lsu_arready;
  logic [DW-1:0] lsu_rdata;
  logic [1:0]    lsu_rresp;
  logic          lsu_rvalid;
  logic          lsu_rready = 1'b1;
  logic [AW-1:0] s_araddr;
  logic          s_arvalid;
  logic          s_arready = 1'b1;
  logic [DW-1:0] s_rdata = '0;
  logic [1:0]    s_rresp = '0;
  logic          s_rvalid = 1'b0;
  logic          s_rready;

  axi_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
    .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
    .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk = 0;
  int nerr = 0;

  logic [AW-1:0] ifu_q[$];
  logic [AW-1:0] lsu_q[$];
  logic [AW-1:0] exp_ar[$];
  logic [34:0]   exp_r[$];   // {master, rresp, rdata}
  logic [33:0]   slv_q[$];   // {rresp, rdata}
  int            acc_q[$];
  int            rcyc_q[$];

  int ar_stall = 0;
  int r_delay_cfg = 0;
  int sar_stall_cnt = 0;
  int r_stall_cnt = 0;
  int lsu_rv_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // IFU master: holds arvalid/araddr until accepted, back-to-back while its queue has work.
  logic ifu_hs;
  initial forever begin
    @(negedge clk);
    ifu_hs = ifu_arvalid & ifu_arready;
    @(posedge clk);
    #1;
    if (!rst_n) ifu_arvalid = 1'b0;
    else begin
      if (ifu_hs) begin
        void'(ifu_q.pop_front());
        ifu_arvalid = 1'b0;
      end
      if (!ifu_arvalid && ifu_q.size() > 0) begin
        ifu_arvalid = 1'b1;
        ifu_araddr  = ifu_q[0];
      end
    end
  end

  logic lsu_hs;
  initial forever begin
    @(negedge clk);
    lsu_hs = lsu_arvalid & lsu_arready;
    @(posedge clk);
    #1;
    if (!rst_n) lsu_arvalid = 1'b0;
    else begin
      if (lsu_hs) begin
        void'(lsu_q.pop_front());
        lsu_arvalid = 1'b0;
      end
      if (!lsu_arvalid && lsu_q.size() > 0) begin
        lsu_arvalid = 1'b1;
        lsu_araddr  = lsu_q[0];
      end
    end
  end

  // Slave model: optional AR stall, R beat r_delay_cfg cycles after the cycle following AR.
  logic        sv_ar_hs, sv_ar_wait, sv_r_hs, slv_pend;
  int          slv_dly;
  logic [33:0] slv_beat;
  initial begin
    slv_pend = 1'b0;
    slv_dly  = 0;
    slv_beat = '0;
    forever begin
      @(negedge clk);
      sv_ar_hs   = rst_n & s_arvalid & s_arready;
      sv_ar_wait = rst_n & s_arvalid & ~s_arready;
      sv_r_hs    = rst_n & s_rvalid & s_rready;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        slv_pend = 1'b0; ar_stall = 0; s_arready = 1'b1;
        s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0;
      end else begin
        if (sv_r_hs) begin
          s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0;
        end
        if (sv_ar_wait && ar_stall > 0) ar_stall--;
        if (sv_ar_hs) begin
          slv_pend = 1'b1;
          slv_dly  = r_delay_cfg;
          slv_beat = (slv_q.size() > 0) ? slv_q.pop_front() : 34'd0;
        end
        if (slv_pend && !s_rvalid) begin
          if (slv_dly == 0) begin
            s_rvalid = 1'b1;
            {s_rresp, s_rdata} = slv_beat;
            slv_pend = 1'b0;
          end else slv_dly--;
        end
        s_arready = (ar_stall == 0);
      end
    end
  end

  // Monitor: protocol invariants plus scoreboard pops on AR and R handshakes.
  logic          busy = 1'b0, own = 1'b0;
  int            acc_cyc = 0;
  logic          sar_prev_stall = 1'b0, sar_prev_v = 1'b0, r_prev_stall = 1'b0;
  logic [AW-1:0] sar_prev_addr = '0;
  logic [33:0]   r_prev = '0, cur_r;
  logic          cur_rv, cur_rr;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      busy = 1'b0; sar_prev_stall = 1'b0; sar_prev_v = 1'b0; r_prev_stall = 1'b0;
    end else begin
      chk("dual_arready", {63'd0, ifu_arready & lsu_arready}, 64'd0);
      if (busy) chk("arready_while_busy", {ifu_arready, lsu_arready}, 64'd0);
      if (ifu_rvalid) chk("ifu_rvalid_owner", {busy, own}, {1'b1, IFU});
      if (lsu_rvalid) begin
        lsu_rv_seen++;
        chk("lsu_rvalid_owner", {busy, own}, {1'b1, LSU});
      end
      cur_rv = own ? lsu_rvalid : ifu_rvalid;
      cur_rr = own ? lsu_rready : ifu_rready;
      cur_r  = own ? {lsu_rresp, lsu_rdata} : {ifu_rresp, ifu_rdata};
      if (r_prev_stall) chk("r_hold", {cur_rv, cur_r}, {1'b1, r_prev});
      if (sar_prev_stall) chk("sar_hold", {s_arvalid, s_araddr}, {1'b1, sar_prev_addr});
      if (s_arvalid && !sar_prev_v) chk("sar_latency", cyc - acc_cyc, 1);
      if (s_arvalid && s_arready) begin
        if (exp_ar.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL sar_unexpected: actual=0x%0h required=none", s_araddr);
        end else chk("s_araddr", s_araddr, exp_ar.pop_front());
      end
      sar_prev_stall = s_arvalid & ~s_arready;
      if (sar_prev_stall) sar_stall_cnt++;
      sar_prev_addr = s_araddr;
      sar_prev_v    = s_arvalid;
      if (busy && cur_rv && cur_rr) begin
        rcyc_q.push_back(cyc);
        busy = 1'b0;
        if (exp_r.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL r_unexpected: actual=0x%0h required=none", {own, cur_r});
        end else chk("r_beat", {own, cur_r}, exp_r.pop_front());
      end
      r_prev_stall = busy & cur_rv & ~cur_rr;
      if (r_prev_stall) r_stall_cnt++;
      r_prev = cur_r;
      if ((ifu_arvalid && ifu_arready) || (lsu_arvalid && lsu_arready)) begin
        busy = 1'b1;
        own  = lsu_arready;
        acc_cyc = cyc;
        acc_q.push_back(cyc);
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    ifu_arvalid = 1'b0;
    lsu_arvalid = 1'b0;
    ifu_q.delete(); lsu_q.delete(); exp_ar.delete(); exp_r.delete(); slv_q.delete();
    r_delay_cfg = 0;
    #1;
    chk("reset_ctrl", {ifu_arready, lsu_arready, ifu_rvalid, lsu_rvalid, s_arvalid, s_rready,
                       ifu_rresp, lsu_rresp}, 64'd0);
    chk("reset_addr", s_araddr, 64'd0);
    chk("reset_rdata", {ifu_rdata, lsu_rdata}, 64'd0);
    ifu_rready = 1'b1;
    lsu_rready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    acc_q.delete(); rcyc_q.delete();
  endtask

  task automatic drain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      #1;
      done = (exp_r.size() == 0) && (exp_ar.size() == 0) && (ifu_q.size() == 0) &&
             (lsu_q.size() == 0) && !busy;
    end
    chk(name, {63'd0, done}, 64'd1);
    if (!done) begin
      exp_r.delete(); exp_ar.delete(); ifu_q.delete(); lsu_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic m, input logic [AW-1:0] a, input logic [1:0] resp,
                       input logic [DW-1:0] d);
    slv_q.push_back({resp, d});
    exp_ar.push_back(a);
    exp_r.push_back({m, resp, d});
    if (m == LSU) lsu_q.push_back(a);
    else ifu_q.push_back(a);
  endtask

  initial begin
    bit seen;
    #2;
    do_reset();

    // 1: IFU alone, zero-wait slave
    lsu_rv_seen = 0;
    issue(IFU, 32'h8000_0000, AXI_RESP_OKAY, 32'h0000_0413);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = ifu_arvalid;
      if (seen) chk("t1_arready_first_cycle", {63'd0, ifu_arready}, 64'd1);
    end
    drain("t1_drain");
    chk("t1_r_latency", (acc_q.size() == 1 && rcyc_q.size() == 1) ? rcyc_q[0] - acc_q[0] : -1, 2);
    chk("t1_lsu_rvalid_seen", lsu_rv_seen, 0);

    // 2: simultaneous requests straight after reset, IFU first
    do_reset();
    issue(IFU, 32'h8000_0004, AXI_RESP_OKAY, 32'h1111_0004);
    issue(LSU, 32'h8000_1000, AXI_RESP_OKAY, 32'h2222_1000);
    drain("t2_drain");

    // 3: both masters back-to-back, strict alternation, 3 cycles per read
    acc_q.delete(); rcyc_q.delete();
    issue(IFU, 32'h8000_0008, AXI_RESP_OKAY, 32'hA000_0008);
    issue(LSU, 32'h8000_2000, AXI_RESP_OKAY, 32'hB000_2000);
    issue(IFU, 32'h8000_000C, AXI_RESP_OKAY, 32'hA000_000C);
    issue(LSU, 32'h8000_2004, AXI_RESP_OKAY, 32'hB000_2004);
    drain("t3_drain");
    chk("t3_num_accepts", acc_q.size(), 4);
    if (acc_q.size() == 4 && rcyc_q.size() == 4) begin
      for (int i = 1; i < 4; i++) chk("t3_accept_gap", acc_q[i] - acc_q[i-1], 3);
      for (int i = 0; i < 4; i++) chk("t3_r_latency", rcyc_q[i] - acc_q[i], 2);
    end

    // 4: AR stalled 5 cycles, owner R stalled 3 cycles, LSU pending meanwhile
    sar_stall_cnt = 0;
    r_stall_cnt = 0;
    ar_stall = 5;
    s_arready = 1'b0;
    ifu_rready = 1'b0;
    issue(IFU, 32'h8000_0010, AXI_RESP_OKAY, 32'hC0DE_0001);
    issue(LSU, 32'h8000_3000, AXI_RESP_OKAY, 32'hC0DE_0002);
    issue(IFU, 32'h8000_0014, AXI_RESP_OKAY, 32'hC0DE_0003);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = ifu_rvalid;
    end
    chk("t4_ifu_rvalid_seen", {63'd0, seen}, 64'd1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 ifu_rready = 1'b1;
    drain("t4_drain");
    chk("t4_ar_stall_cycles", sar_stall_cnt, 5);
    chk("t4_r_stall_cycles", r_stall_cnt, 3);

    // 5: error responses pass through; LSU first since IFU won last
    acc_q.delete(); rcyc_q.delete();
    issue(LSU, 32'h8000_4000, AXI_RESP_SLVERR, 32'hDEAD_BEEF);
    issue(IFU, 32'h8000_0018, AXI_RESP_DECERR, 32'h0BAD_F00D);
    drain("t5_drain");
    chk("t5_idle_after_err", (acc_q.size() == 2) ? acc_q[1] - acc_q[0] : -1, 3);

    // 6: reset while an LSU beat is stalled in WAIT_R
    lsu_rready = 1'b0;
    slv_q.push_back({AXI_RESP_OKAY, 32'h5555_AAAA});
    exp_ar.push_back(32'h8000_5000);
    lsu_q.push_back(32'h8000_5000);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      seen = lsu_rvalid;
    end
    chk("t6_lsu_rvalid_seen", {63'd0, seen}, 64'd1);
    #1;
    do_reset();
    issue(IFU, 32'h8000_0020, AXI_RESP_OKAY, 32'h6666_0020);
    issue(LSU, 32'h8000_5004, AXI_RESP_OKAY, 32'h7777_5004);
    drain("t6_drain");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
